// File: rtl/hpf_approx_mac.sv
// Sequential single-MAC FIR high-pass stage with one tap per cycle.
// The low APPROX_BITS accumulator bits use a selectable approximate-sum full adder.
module hpf_approx_mac #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned COEF_W      = 16,
  parameter int unsigned TAPS        = 8,
  parameter int unsigned APPROX_BITS = 0,
  parameter int unsigned AFA_MODE    = 0,
  parameter int unsigned OUT_SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic                      busy
);

  localparam int unsigned AW       = $clog2(TAPS);
  localparam int unsigned P_W      = DATA_W + COEF_W;
  localparam int unsigned ACC_W    = P_W + AW;
  localparam int          APPROX_I = int'(APPROX_BITS);
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_EXT = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t                    state, state_next;
  logic                      in_ready_d, out_valid_d, busy_d;

  logic signed [DATA_W-1:0]  x [TAPS];
  logic signed [COEF_W-1:0]  h [TAPS];
  logic [ACC_W-1:0]          acc;
  logic [AW-1:0]             tap;

  logic signed [P_W-1:0]     prod_c;
  logic [ACC_W-1:0]          addend_c;
  logic signed [ACC_W-1:0]   sum_c;
  logic signed [ACC_W-1:0]   shifted_c;
  logic [DATA_W-1:0]         sat_c;

  // Sum output of one fa_approx cell at bit position idx.
  function automatic logic fa_sum(input logic a, input logic b, input logic c, input int idx);
    logic s;
    s = a ^ b ^ c;
    if (idx < APPROX_I) begin
      case (AFA_MODE)
        1:       s = a ^ b;
        2:       s = (~a | b) & c;
        3:       s = b;
        default: s = a ^ b ^ c;
      endcase
    end
    return s;
  endfunction

  // Product of the current tap and the ripple chain of fa_approx cells.
  always_comb begin
    logic c;
    prod_c   = P_W'(h[tap]) * P_W'(x[tap]);
    addend_c = {{AW{prod_c[P_W-1]}}, prod_c};
    sum_c    = '0;
    c        = 1'b0;
    for (int i = 0; i < int'(ACC_W); i++) begin
      sum_c[i] = fa_sum(acc[i], addend_c[i], c, i);
      c        = (acc[i] & addend_c[i]) | (acc[i] & c) | (addend_c[i] & c);
    end
  end

  // Scale, then clamp to the signed output range.
  always_comb begin
    shifted_c = sum_c >>> OUT_SHIFT;
    if ((&shifted_c[ACC_W-1:DATA_W-1]) || !(|shifted_c[ACC_W-1:DATA_W-1])) begin
      sat_c = shifted_c[DATA_W-1:0];
    end else if (shifted_c[ACC_W-1]) begin
      sat_c = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = MAC;
      MAC:     if (tap == LAST_TAP) state_next = HOLD;
      HOLD:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave a flop.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    in_ready_d  = (state_next == IDLE);
    out_valid_d = (state_next == HOLD);
    busy_d      = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Coefficient bank, delay line and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
      acc      <= '0;
      tap      <= '0;
      out_data <= '0;
    end else begin
      if (state == IDLE && coef_we && ({1'b0, coef_addr} < TAPS_EXT)) begin
        h[coef_addr] <= coef_wdata;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            x[0] <= in_data;
            for (int i = 1; i < int'(TAPS); i++) x[i] <= x[i-1];
            acc <= '0;
            tap <= '0;
          end
        end
        MAC: begin
          acc <= sum_c;
          tap <= tap + AW'(1);
          if (tap == LAST_TAP) out_data <= sat_c;
        end
        default: ;
      endcase
    end
  end

endmodule
